branch_predictor: RTL
=====================

# branch_predictor

Fetch-side branch predictor for the pipelined CPU, paired with the branch comparison unit. It predicts direction and target for predecoded branches at fetch, using a direct-mapped table of 2-bit saturating counters with a tagged target buffer. Each prediction is held in an in-order queue until the branch decision from the comparison stage comes back. Resolution trains the table and raises a one-cycle mispredict/redirect pulse that flushes wrong-path state.

## Interface
Parameters:
- INDEX_BITS, 6, table index width (2^INDEX_BITS entries), index = pc[INDEX_BITS+1:2]
- QUEUE_DEPTH, 4, in-flight unresolved branches (power of two, ≥2)

Ports:
- clk  input  1  core clock
- rst  input  1  reset; asynchronous, active-high
- fetch_valid  input  1  fetch_pc valid this cycle
- fetch_pc  input  32  fetch address (word aligned)
- fetch_is_branch  input  1  predecode: instruction is a conditional branch
- pred_taken  output  1  predicted direction (combinational)
- pred_target  output  32  predicted next PC (combinational)
- fetch_stall  output  1  branch cannot be accepted (queue full)
- resolve_valid  input  1  oldest branch resolved this cycle
- resolve_taken  input  1  actual direction (comparison-unit branch output)
- resolve_target  input  32  actual branch target
- mispredict  output  1  registered one-cycle pulse: redirect fetch
- redirect_pc  output  32  correct next PC, valid with mispredict
- protocol_err  output  1  sticky: resolve received with empty queue

## Operation
- Per entry: ctr[1:0], valid, tag = pc[31:INDEX_BITS+2], target[31:0].
- Hit = valid && tag match at index(fetch_pc).
- pred_taken = fetch_valid && fetch_is_branch && hit && ctr[1].
- pred_target = pred_taken ? entry.target : fetch_pc+4, wrapping mod 2^32.
- Accept: fetch_valid && fetch_is_branch && !full.
  - Push {pc, pred_taken, pred_target} on accept.
  - fetch_stall = fetch_valid && fetch_is_branch && full.
- Resolve: resolve_valid && !empty pops the head.
  - wrong = head.taken != resolve_taken || (resolve_taken && head.target != resolve_target).
  - Counter at index(head.pc): taken → saturating increment (max 11); not taken → saturating decrement (min 00).
  - Write tag, target and valid=1 when resolve_taken; when not taken, only the counter changes.
  - New entries (tag miss on a taken update) start at ctr=10.
- Mispredict: when wrong, on the same edge:
  - flush the whole queue (younger entries are wrong path);
  - set mispredict=1 for one cycle;
  - redirect_pc = resolve_taken ? resolve_target : head.pc+4.
- Resolve with empty queue: no pop, no table change, no mispredict; set protocol_err until reset.

## Timing
- Reset (asynchronous, active-high):
  - all ctr=01, all valid=0, queue empty;
  - mispredict=0, redirect_pc=0, protocol_err=0.
  - Combinational outputs follow inputs: with fetch_valid=0 they are pred_taken=0, pred_target=fetch_pc+4, fetch_stall=0.
- Prediction: zero latency, combinational from fetch_pc.
- Table write: at the resolve edge. A same-cycle predict to the same index sees the old value.
- mispredict/redirect_pc: registered, asserted exactly the cycle after the resolve edge. redirect_pc holds its value while mispredict=0.
- Push and pop in the same cycle (no mispredict): both happen, occupancy unchanged. Allowed when full: the pop frees the slot, so fetch_stall is based on occupancy excluding the pop.
- Push and mispredicting pop in the same cycle: flush wins, the push is dropped, queue ends empty.
- Pointers wrap modulo QUEUE_DEPTH. full = count==QUEUE_DEPTH, empty = count==0.
- Reset mid-operation: queue discarded, table reinitialised, any pending mispredict pulse cancelled.

## Structure
- Shared header alongside the BCU control encodings holds:
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - default INDEX_BITS and QUEUE_DEPTH.
- Sub-module bp_queue: parameterised FIFO with push, pop, flush, full, empty and a head read port. The table and control logic stay in branch_predictor.

## Test plan
- Reset, fetch branch at pc=0x100 → pred_taken=0, pred_target=0x104; fetch_stall=0.
- Resolve 0x100 taken to 0x200 twice, fetching again between the resolves:
  - 1st resolve is wrong (predicted not taken): mispredict pulse, redirect_pc=0x200, entry created at ctr=10;
  - 2nd fetch predicts taken 0x200, 2nd resolve is correct (no mispredict), ctr=11;
  - next fetch → pred_taken=1, pred_target=0x200.
- Trained 0x100 at ST, resolve not taken → mispredict, redirect_pc=0x104, ctr=10, queue flushed (3 queued entries gone, next resolve sets protocol_err).
- Push 4 branches with no resolve → fetch_stall=1 on 5th; same cycle resolve_valid correct → push accepted, count stays 4.
- resolve_valid with empty queue → protocol_err=1 and stays 1; no mispredict, table unchanged.
- Mispredicting resolve with concurrent push, then rst asserted mid-cycle → queue empty, mispredict=0 immediately, ctr reads 01.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared branch-predictor definitions: counter encodings, default sizing and
// the layout of one in-flight prediction record.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int DEFAULT_INDEX_BITS  = 6;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bq_entry_t;

endpackage

// File: rtl/branch_predictor_queue.sv
// In-order FIFO of unresolved predictions. Flush overrides push and pop;
// a push while full is only accepted when a pop frees the head slot.
module bp_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];

  // pointer/occupancy control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor: direct-mapped 2-bit counters with a
// tagged target buffer, trained in order as branches resolve.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS  = DEFAULT_INDEX_BITS,
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_is_branch,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        fetch_stall,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        protocol_err
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  function automatic ctr_e sat_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e sat_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

  ctr_e             ctr_q   [ENTRIES];
  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx_p0;
  logic [TAG_W-1:0]      fetch_tag_p0;
  logic                  fetch_hit_p0;
  logic                  fetch_branch_p0;
  logic                  push_p0;

  bq_entry_t             push_entry_p0;
  bq_entry_t             head_p0;
  logic [$bits(bq_entry_t)-1:0] head_raw_p0;
  logic                  q_full;
  logic                  q_empty;

  logic                  pop_p0;
  logic                  wrong_p0;
  logic                  flush_p0;
  logic [INDEX_BITS-1:0] head_idx_p0;
  logic [TAG_W-1:0]      head_tag_p0;
  logic                  head_hit_p0;
  ctr_e                  ctr_next_p0;

  logic                  mispredict_p1;
  logic [31:0]           redirect_pc_p1;
  logic                  protocol_err_p1;

  // fetch stage: combinational lookup and queue admission
  assign fetch_idx_p0    = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag_p0    = fetch_pc[31:INDEX_BITS+2];
  assign fetch_hit_p0    = valid_q[fetch_idx_p0] && (tag_q[fetch_idx_p0] == fetch_tag_p0);
  assign fetch_branch_p0 = fetch_valid && fetch_is_branch;
  assign pred_taken      = fetch_branch_p0 && fetch_hit_p0 && ctr_q[fetch_idx_p0][1];
  assign pred_target     = pred_taken ? tgt_q[fetch_idx_p0] : fetch_pc + 32'd4;
  assign fetch_stall     = fetch_branch_p0 && q_full && !pop_p0;
  assign push_p0         = fetch_branch_p0 && !fetch_stall;

  assign push_entry_p0 = '{pc: fetch_pc, taken: pred_taken, target: pred_target};
  assign head_p0       = head_raw_p0;

  bp_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     ($bits(bq_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p0),
    .pop   (pop_p0),
    .flush (flush_p0),
    .din   (push_entry_p0),
    .head  (head_raw_p0),
    .full  (q_full),
    .empty (q_empty)
  );

  // resolve stage: compare against the oldest prediction and compute training
  assign pop_p0      = resolve_valid && !q_empty;
  assign wrong_p0    = (head_p0.taken != resolve_taken) ||
                       (resolve_taken && (head_p0.target != resolve_target));
  assign flush_p0    = pop_p0 && wrong_p0;
  assign head_idx_p0 = head_p0.pc[INDEX_BITS+1:2];
  assign head_tag_p0 = head_p0.pc[31:INDEX_BITS+2];
  assign head_hit_p0 = valid_q[head_idx_p0] && (tag_q[head_idx_p0] == head_tag_p0);
  assign ctr_next_p0 = resolve_taken ? (head_hit_p0 ? sat_inc(ctr_q[head_idx_p0]) : WT)
                                     : sat_dec(ctr_q[head_idx_p0]);

  // table counters and valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]   <= WNT;
        valid_q[i] <= 1'b0;
      end
    end else if (pop_p0) begin
      ctr_q[head_idx_p0] <= ctr_next_p0;
      if (resolve_taken) valid_q[head_idx_p0] <= 1'b1;
    end
  end

  // table tags and targets, written only by taken resolutions
  always_ff @(posedge clk) begin
    if (pop_p0 && resolve_taken) begin
      tag_q[head_idx_p0] <= head_tag_p0;
      tgt_q[head_idx_p0] <= resolve_target;
    end
  end

  // redirect stage: registered mispredict pulse and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_p1   <= 1'b0;
      redirect_pc_p1  <= '0;
      protocol_err_p1 <= 1'b0;
    end else begin
      mispredict_p1 <= flush_p0;
      if (flush_p0) redirect_pc_p1 <= resolve_taken ? resolve_target : head_p0.pc + 32'd4;
      if (resolve_valid && q_empty) protocol_err_p1 <= 1'b1;
    end
  end

  assign mispredict   = mispredict_p1;
  assign redirect_pc  = redirect_pc_p1;
  assign protocol_err = protocol_err_p1;

endmodule
